// File: rtl/uart_port.sv
// Memory-mapped UART: TX FIFO with 8N1 transmitter, single-byte RX holding register, status word.
// Latency: txd falls one cycle after the FIFO push edge; rx_valid rises on the stop-bit sample edge.
// Backpressure: DATA writes to a full FIFO are dropped and flagged sticky tx_drop; an unread RX byte is overwritten (rx_overrun).
module uart_port #(
  parameter int CLK_HZ   = 25000000,
  parameter int BAUD     = 115200,
  parameter int TX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        addr,
  input  logic        we,
  input  logic        re,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        txd,
  input  logic        rxd,
  output logic        rx_irq
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam int PW  = $clog2(TX_DEPTH);
  localparam int NW  = $clog2(TX_DEPTH + 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  // Only the low byte of the bus carries payload.
  logic unused_wdata;
  assign unused_wdata = ^wdata[15:8];

  logic [7:0]    fifo_mem [TX_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] fifo_cnt_q, fifo_cnt_d;
  tx_state_t     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          txd_q, txd_d;
  logic          rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          tx_drop_q, tx_drop_d, rx_ferr_q, rx_ferr_d, rx_ovr_q, rx_ovr_d;

  logic fifo_full, fifo_empty, push, pop, data_wr, data_rd, stat_rd;
  logic rx_done, rx_ferr_set, tx_idle;

  assign fifo_full  = (fifo_cnt_q == NW'(TX_DEPTH));
  assign fifo_empty = (fifo_cnt_q == '0);
  assign data_wr    = sel & we & ~addr;
  assign data_rd    = sel & re & ~addr;
  assign stat_rd    = sel & re & addr;
  // Fullness is judged before the edge, so a same-cycle pop never frees a slot for this write.
  assign push       = data_wr & ~fifo_full;
  assign tx_idle    = fifo_empty & (tx_state_q == TX_IDLE);

  // Read mux: combinational from current state, zero when not selected.
  always_comb begin
    rdata = 16'h0000;
    if (sel) begin
      if (addr) rdata = {10'b0, tx_drop_q, rx_ferr_q, rx_ovr_q, tx_idle, rx_valid_q, ~fifo_full};
      else      rdata = {8'h00, rx_data_q};
    end
  end

  assign txd    = txd_q;
  assign rx_irq = rx_valid_q;

  // TX framing: pops the FIFO head at frame start, holds each bit DIV cycles, chains frames without a gap.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    pop        = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          tx_shift_d = fifo_mem[rd_ptr_q];
          txd_d      = 1'b0;
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == CW'(DIV - 1)) begin
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          txd_d      = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == CW'(DIV - 1)) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == CW'(DIV - 1)) begin
          tx_cnt_d = '0;
          if (!fifo_empty) begin
            pop        = 1'b1;
            tx_shift_d = fifo_mem[rd_ptr_q];
            txd_d      = 1'b0;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // FIFO pointers wrap naturally at TX_DEPTH; occupancy tracked separately.
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + NW'(1);
    else if (!push && pop) fifo_cnt_d = fifo_cnt_q - NW'(1);
  end

  // RX: start-bit validation at mid-bit, then one sample per bit period.
  always_comb begin
    rx_s1_d     = rxd;
    rx_s2_d     = rx_s1_q;
    rx_prev_d   = rx_s2_q;
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_done     = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_cnt_d   = CW'(1);
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == CW'(DIV / 2)) begin
          if (rx_s2_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_cnt_d   = CW'(1);
            rx_bit_d   = 3'd0;
            rx_state_d = RX_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CW'(DIV)) begin
          rx_cnt_d   = CW'(1);
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CW'(DIV)) begin
          rx_cnt_d = '0;
          if (rx_s2_q) begin
            rx_done    = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_ferr_set = 1'b1;
            rx_state_d  = RX_WAIT_HIGH;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s2_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Holding register and sticky flags: a new byte beats a same-cycle read, a set beats a same-cycle clear.
  always_comb begin
    rx_data_d  = rx_done ? rx_shift_q : rx_data_q;
    rx_valid_d = rx_done ? 1'b1 : (data_rd ? 1'b0 : rx_valid_q);
    rx_ovr_d   = (rx_done & rx_valid_q & ~data_rd) | (rx_ovr_q & ~stat_rd);
    rx_ferr_d  = rx_ferr_set | (rx_ferr_q & ~stat_rd);
    tx_drop_d  = (data_wr & fifo_full) | (tx_drop_q & ~stat_rd);
  end

  // FIFO storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= wdata[7:0];
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_drop_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_prev_q  <= rx_prev_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_drop_q  <= tx_drop_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

endmodule

// File: tb/tb_uart_port.sv
// Directed bench for uart_port at CLK_HZ=16, BAUD=1 (16 cycles per bit).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Status bits: [5]tx_drop [4]rx_frame_err [3]rx_overrun [2]tx_idle [1]rx_valid [0]tx_ready.
module tb_uart_port;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0, addr = 1'b0, we = 1'b0, re = 1'b0;
  logic [15:0] wdata = 16'h0000;
  logic        rxd = 1'b1;
  logic [15:0] rdata;
  logic        txd, rx_irq;

  int checks   = 0;
  int failures = 0;

  uart_port #(.CLK_HZ(16), .BAUD(1), .TX_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .sel(sel), .addr(addr), .we(we), .re(re),
    .wdata(wdata), .rdata(rdata), .txd(txd), .rxd(rxd), .rx_irq(rx_irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Line level of an 8N1 frame: level 0 = start, 1..8 = data LSB first, 9 = stop.
  function automatic logic frame_lvl(input logic [7:0] b, input int lvl);
    if (lvl == 0) return 1'b0;
    if (lvl == 9) return 1'b1;
    return b[lvl-1];
  endfunction

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(16);
    end
    rxd = stop_bit;
    tick(16);
    rxd = 1'b1;
    tick(4);
  endtask

  task automatic peek_status(input string tag, input logic [15:0] exp);
    sel = 1'b1; addr = 1'b1; we = 1'b0; re = 1'b0;
    #1;
    chk(tag, rdata, exp);
  endtask

  logic [7:0] tx_bytes [5];

  initial begin
    // Reset held for a few cycles.
    tick(3);
    chk("rst_txd", {15'b0, txd}, 16'h0001);
    chk("rst_irq", {15'b0, rx_irq}, 16'h0000);
    rst = 1'b1;
    tick(1);
    peek_status("rst_status", 16'h0005);
    addr = 1'b0; #1;
    chk("rst_rxdata", rdata, 16'h0000);
    sel = 1'b0; #1;
    chk("unsel_rdata", rdata, 16'h0000);

    // Single byte 0x55: txd low one cycle after the push edge, 10 levels of 16 cycles.
    sel = 1'b1; addr = 1'b0; we = 1'b1; wdata = 16'h1255;
    tick(1);                              // push edge = cycle 0
    we = 1'b0; addr = 1'b1;
    chk("tx1_k0_txd", {15'b0, txd}, 16'h0001);
    for (int k = 1; k <= 161; k++) begin
      tick(1);
      if (k == 1) chk("tx1_start_edge", {15'b0, txd}, 16'h0000);
      if (k <= 160 && ((k - 1) % 16) == 8)
        chk($sformatf("tx1_lvl%0d", (k - 1) / 16), {15'b0, txd},
            {15'b0, frame_lvl(8'h55, (k - 1) / 16)});
      if (k == 160) chk("tx1_busy_160", rdata, 16'h0001);
      if (k == 161) chk("tx1_idle_161", rdata, 16'h0005);
    end

    // Six back-to-back writes. The first pop happens on the second write edge,
    // so occupancy after each edge is 1,1,2,3,4 and the sixth write sees full: 0x06 dropped.
    tx_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    addr = 1'b0; we = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wdata = 16'(i + 1);
      tick(1);                            // after loop: cycle 5 relative to first push
    end
    we = 1'b0;
    peek_status("b2b_full_drop", 16'h0020);
    for (int k = 6; k <= 801; k++) begin
      tick(1);
      if (k <= 800) begin
        if (((k - 1) % 16) == 8)
          chk($sformatf("b2b_f%0d_lvl%0d", (k - 1) / 160, ((k - 1) % 160) / 16), {15'b0, txd},
              {15'b0, frame_lvl(tx_bytes[(k - 1) / 160], ((k - 1) % 160) / 16)});
        if (((k - 1) % 160) == 0)
          chk($sformatf("b2b_f%0d_nogap", (k - 1) / 160), {15'b0, txd}, 16'h0000);
        if (((k - 1) % 160) == 159)
          chk($sformatf("b2b_f%0d_stop_last", (k - 1) / 160), {15'b0, txd}, 16'h0001);
      end
      if (k == 800) chk("b2b_busy_800", rdata, 16'h0021);
      if (k == 801) chk("b2b_idle_801", rdata, 16'h0025);
    end
    re = 1'b1; tick(1); re = 1'b0;        // STATUS read clears tx_drop
    peek_status("b2b_drop_cleared", 16'h0005);

    // RX 0xA3 with good stop bit.
    send_rx(8'hA3, 1'b1);
    peek_status("rxA3_status", 16'h0007);
    chk("rxA3_irq", {15'b0, rx_irq}, 16'h0001);
    addr = 1'b0; re = 1'b1; #1;
    chk("rxA3_data", rdata, 16'h00A3);
    tick(1); re = 1'b0;
    peek_status("rxA3_consumed", 16'h0005);
    chk("rxA3_irq_clr", {15'b0, rx_irq}, 16'h0000);

    // Two frames without a read: overrun, latest byte kept.
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    peek_status("ovr_status", 16'h000F);
    re = 1'b1; tick(1); re = 1'b0;
    addr = 1'b0; re = 1'b1; #1;
    chk("ovr_data", rdata, 16'h0022);
    tick(1); re = 1'b0;
    peek_status("ovr_cleared", 16'h0005);

    // Bad stop bit: frame error, holding register untouched.
    send_rx(8'h7E, 1'b0);
    tick(4);
    peek_status("ferr_status", 16'h0015);
    addr = 1'b0; #1;
    chk("ferr_data_kept", rdata, 16'h0022);
    addr = 1'b1; re = 1'b1; tick(1); re = 1'b0;
    peek_status("ferr_cleared", 16'h0005);

    // 8-cycle low glitch is rejected at the mid-bit check.
    rxd = 1'b0; tick(8); rxd = 1'b1;
    tick(200);
    peek_status("glitch_status", 16'h0005);

    // Receiver still works after the glitch.
    send_rx(8'h5A, 1'b1);
    peek_status("rx5A_status", 16'h0007);

    // Unselected accesses and STATUS writes have no effect.
    sel = 1'b0; #1;
    chk("unsel_rdata_valid", rdata, 16'h0000);
    addr = 1'b0; we = 1'b1; re = 1'b1; wdata = 16'h00FF;
    tick(1); we = 1'b0; re = 1'b0;
    tick(3);
    chk("unsel_txd", {15'b0, txd}, 16'h0001);
    sel = 1'b1; addr = 1'b1; we = 1'b1; wdata = 16'h003F;
    tick(1); we = 1'b0;
    tick(3);
    peek_status("stat_wr_noeffect", 16'h0007);
    chk("stat_wr_txd", {15'b0, txd}, 16'h0001);
    addr = 1'b0; #1;
    chk("rx5A_data", rdata, 16'h005A);

    // Reset mid-frame on both directions.
    rxd = 1'b0;
    sel = 1'b1; addr = 1'b0; we = 1'b1; wdata = 16'h0000;
    tick(1); we = 1'b0;
    tick(40);
    chk("midrst_txd_before", {15'b0, txd}, 16'h0000);
    #2 rst = 1'b0;
    #1;
    chk("midrst_txd_async", {15'b0, txd}, 16'h0001);
    rxd = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(200);
    peek_status("midrst_status", 16'h0005);
    addr = 1'b0; #1;
    chk("midrst_rxdata", rdata, 16'h0000);
    chk("midrst_txd_idle", {15'b0, txd}, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_port.md
Name: uart_port

Overview:
- Memory-mapped UART peripheral on the CPU data-memory port (port B), selected by the address-decode stage when the logical address falls in the I/O window.
- Provides a TX FIFO, a single-byte RX holding register and a status word.
- Runs on the 25 MHz system clock and drives the board serial pins.

Parameters:
- CLK_HZ, 25000000, system clock frequency.
- BAUD, 115200, line rate; DIV = CLK_HZ/BAUD, integer truncated (217 at defaults), cycles per bit.
- TX_DEPTH, 4, TX FIFO entries (power of two, ≥2).

Ports:
- clk  input  1  system clock (25 MHz); all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- sel  input  1  peripheral selected by address decode.
- addr  input  1  register select: 0 = DATA, 1 = STATUS.
- we  input  1  write strobe, one cycle per access.
- re  input  1  read strobe, one cycle per access.
- wdata  input  16  write data; only [7:0] used.
- rdata  output  16  read data, combinational from current state.
- txd  output  1  serial transmit line, idle high.
- rxd  input  1  serial receive line, asynchronous.
- rx_irq  output  1  equals rx_valid.

Behaviour:
- Reset: txd=1, TX FIFO empty, both FSMs IDLE, rx_data=0, rx_valid=0, sticky bits 0, rxd synchronizer flops=1, bit counters 0.
- sel=0: we/re ignored, rdata=0.
- DATA read: rdata = {8'h00, rx_data}. On that edge rx_valid clears.
- STATUS read: rdata = {10'b0, tx_drop, rx_frame_err, rx_overrun, tx_idle, rx_valid, tx_ready}.
  - tx_ready = FIFO not full.
  - tx_idle = FIFO empty and TX FSM in IDLE.
  - On the read edge, sticky bits tx_drop, rx_frame_err and rx_overrun clear.
- DATA write: pushes wdata[7:0] if FIFO not full, judged by pre-edge count; a same-cycle pop does not make room. If full, the byte is dropped and tx_drop is set.
- STATUS write: no effect.
- TX FSM: IDLE → START → DATA → STOP.
  - IDLE with FIFO non-empty: pop the head into the shifter and go to START; txd=0 from the next cycle.
  - Each bit holds for exactly DIV cycles.
  - DATA sends 8 bits LSB first. STOP drives txd=1.
  - At the end of STOP: FIFO non-empty → START directly (no idle gap, frame = 10·DIV cycles); otherwise IDLE.
- RX input: rxd passes through a 2-flop synchronizer; all RX logic uses the synchronized value.
- RX FSM: IDLE → START → DATA → STOP → (WAIT_HIGH).
  - IDLE: 1→0 transition starts the counter.
  - START: sample at DIV/2. If high, it is a glitch → IDLE.
  - DATA: sample every DIV cycles thereafter, 8 bits LSB first.
  - STOP, sampled 1: load rx_data and set rx_valid. If rx_valid was already 1, set rx_overrun and overwrite. → IDLE.
  - STOP, sampled 0: set rx_frame_err, discard the byte, go to WAIT_HIGH until the line is 1, then IDLE.
- Simultaneous RX completion and DATA read in the same cycle: the new byte wins; rx_valid stays 1 with the new data; no overrun.
- Simultaneous sticky-set and STATUS read in the same cycle: set wins (bit reads 1 next time).
- FIFO pointers are log2(TX_DEPTH) bits wide with a separate count 0..TX_DEPTH; pointers wrap modulo TX_DEPTH.
- Reset asserted mid-frame aborts immediately: txd=1 asynchronously, partial RX byte discarded.

Test Plan:
- All tests use CLK_HZ=16, BAUD=1 (DIV=16).
- Reset, then STATUS read → rdata=16'h0005 (tx_ready=1, tx_idle=1); txd=1.
- Write DATA 16'h1255 → txd low 1 cycle after the push edge. Line pattern 0,1,0,1,0,1,0,1,0,1, each level 16 cycles. tx_idle returns to 1 at cycle 161.
- Write 6 bytes 0x01..0x06 back-to-back, no gap. FIFO accepts 4; the 5th is taken after the first pop; the 6th is dropped only if the FIFO is full, per the pre-edge count (bench computes exact). tx_drop=1; frames are contiguous, with no idle cycles between stop and start.
- Drive rxd frame 0xA3 with a valid stop bit → rx_valid=1, rx_irq=1. DATA read returns 16'h00A3; rx_valid=0 next cycle.
- Drive two frames 0x11, 0x22 with no read between → STATUS shows rx_overrun=1 and rx_valid=1. DATA read returns 0x0022. A second STATUS read shows rx_overrun=0.
- Drive frame 0x7E with stop bit 0 → rx_frame_err=1, rx_valid unchanged. An 8-cycle low glitch on an idle line → no byte, no error.
